// File: rtl/rstmgr_pwr_seq.sv
// Reset sequencer: turns per-domain lifecycle/system reset requests into ordered,
// release-stretched source resets and keeps sticky per-domain reset-cause flags.
module rstmgr_pwr_seq #(
  parameter int unsigned PowerDomains = 2,
  parameter int unsigned RelCycles    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PowerDomains-1:0] rst_lc_req_i,
  input  logic [PowerDomains-1:0] rst_sys_req_i,
  input  logic [1:0]              reset_cause_i,
  input  logic                    cause_clr_i,
  output logic [PowerDomains-1:0] rst_lc_src_n_o,
  output logic [PowerDomains-1:0] rst_sys_src_n_o,
  output logic [PowerDomains-1:0] cause_hw_o,
  output logic [PowerDomains-1:0] cause_lp_o,
  output logic                    seq_busy_o
);

  localparam int unsigned     CntW        = $clog2(RelCycles + 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(RelCycles - 1);
  localparam logic [1:0]      CauseLowPwr = 2'd1;
  localparam logic [1:0]      CauseHwReq  = 2'd2;

  typedef enum logic [1:0] {
    TreeAsserted = 2'd0,
    TreeStretch  = 2'd1,
    TreeReleased = 2'd2
  } tree_state_e;

  typedef struct packed {
    tree_state_e     state;
    logic [CntW-1:0] cnt;
  } tree_t;

  localparam tree_t TreeReset = '{state: TreeAsserted, cnt: '0};

  tree_t lc_q  [PowerDomains];
  tree_t lc_d  [PowerDomains];
  tree_t sys_q [PowerDomains];
  tree_t sys_d [PowerDomains];

  logic [PowerDomains-1:0] lc_released;
  logic [PowerDomains-1:0] lc_perm;
  logic [PowerDomains-1:0] sys_req_eff;
  logic [PowerDomains-1:0] lc_enter;
  logic [PowerDomains-1:0] sys_enter;
  logic [PowerDomains-1:0] set_hw;
  logic [PowerDomains-1:0] set_lp;

  // A request always wins; permission only gates leaving ASSERTED and staying in STRETCH.
  function automatic tree_t tree_next(tree_t cur, logic req, logic perm);
    tree_t nxt;
    nxt = cur;
    if (req) begin
      nxt = TreeReset;
    end else begin
      case (cur.state)
        TreeAsserted: begin
          if (perm) nxt = '{state: TreeStretch, cnt: '0};
        end
        TreeStretch: begin
          if (!perm)                 nxt = TreeReset;
          else if (cur.cnt == CntLast) nxt = '{state: TreeReleased, cnt: '0};
          else                       nxt.cnt = cur.cnt + CntW'(1);
        end
        TreeReleased: nxt = cur;
        default:      nxt = TreeReset;
      endcase
    end
    return nxt;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lc_released = '0;
    for (int i = 0; i < PowerDomains; i++) begin
      lc_released[i] = (lc_q[i].state == TreeReleased);
    end
  end

  always_comb begin
    lc_perm     = '0;
    sys_req_eff = '0;
    for (int i = 0; i < PowerDomains; i++) begin
      lc_perm[i]     = (i == 0) ? 1'b1 : lc_released[0];
      sys_req_eff[i] = rst_sys_req_i[i] | rst_lc_req_i[i] | ~lc_released[i];
    end
  end

  always_comb begin
    for (int i = 0; i < PowerDomains; i++) begin
      lc_d[i]      = tree_next(lc_q[i], rst_lc_req_i[i], lc_perm[i]);
      sys_d[i]     = tree_next(sys_q[i], sys_req_eff[i], 1'b1);
      lc_enter[i]  = (lc_q[i].state != TreeAsserted) && (lc_d[i].state == TreeAsserted);
      sys_enter[i] = (sys_q[i].state != TreeAsserted) && (sys_d[i].state == TreeAsserted);
    end
  end

  assign set_hw = (lc_enter | sys_enter) & {PowerDomains{reset_cause_i == CauseHwReq}};
  assign set_lp = (lc_enter | sys_enter) & {PowerDomains{reset_cause_i == CauseLowPwr}};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PowerDomains; i++) begin
        lc_q[i]  <= TreeReset;
        sys_q[i] <= TreeReset;
      end
      cause_hw_o <= '0;
      cause_lp_o <= '0;
    end else begin
      for (int i = 0; i < PowerDomains; i++) begin
        lc_q[i]  <= lc_d[i];
        sys_q[i] <= sys_d[i];
      end
      // A set in the same cycle as a clear must survive the clear.
      cause_hw_o <= (cause_hw_o & ~{PowerDomains{cause_clr_i}}) | set_hw;
      cause_lp_o <= (cause_lp_o & ~{PowerDomains{cause_clr_i}}) | set_lp;
    end
  end

  // Outputs decode state flops only, so inputs never reach them combinationally.
  always_comb begin
    rst_lc_src_n_o  = '0;
    rst_sys_src_n_o = '0;
    seq_busy_o      = 1'b0;
    for (int i = 0; i < PowerDomains; i++) begin
      rst_lc_src_n_o[i]  = (lc_q[i].state == TreeReleased);
      rst_sys_src_n_o[i] = (sys_q[i].state == TreeReleased);
      seq_busy_o = seq_busy_o | (lc_q[i].state == TreeStretch) | (sys_q[i].state == TreeStretch);
    end
  end

endmodule

// File: doc/rstmgr_pwr_seq.md
# rstmgr_pwr_seq

Reset sequencer that consumes the power manager fast FSM's per-domain reset requests (`rst_lc_req`, `rst_sys_req`, `reset_cause`). It drives the per-domain `rst_lc_src_n` / `rst_sys_src_n` source resets, which the fast FSM reads back to decide when resets are asserted or released. Assertion is immediate. Release is stretched by a programmable count and strictly ordered: always-on lifecycle first, then dependent trees. It also keeps a sticky record of why each off-domain was last reset.

## Interface
Parameters:
- `PowerDomains`, 2: number of power domains; index 0 is always-on.
- `RelCycles`, 4: release stretch length in cycles; must be ≥1. Counter width is `$clog2(RelCycles+1)`.

Ports:
- `clk_i`, in, 1: fast clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `rst_lc_req_i`, in, PowerDomains: per-domain lifecycle reset request, 1 = hold in reset.
- `rst_sys_req_i`, in, PowerDomains: per-domain system reset request.
- `reset_cause_i`, in, 2: 0 ResetNone, 1 LowPwrEntry, 2 HwReq, 3 ResetUndefined.
- `cause_clr_i`, in, 1: clears the sticky cause flags.
- `rst_lc_src_n_o`, out, PowerDomains: lifecycle source reset, active-low.
- `rst_sys_src_n_o`, out, PowerDomains: system source reset, active-low.
- `cause_hw_o`, out, PowerDomains: sticky flag, domain was reset under HwReq.
- `cause_lp_o`, out, PowerDomains: sticky flag, domain was reset under LowPwrEntry.
- `seq_busy_o`, out, 1: at least one tree is in Stretch.

## Operation
- There are 2×PowerDomains independent tree FSMs, one lifecycle (lc) and one system (sys) per domain.
- Each tree FSM has three states: ASSERTED, STRETCH, RELEASED. Output `_n` = 1 only in RELEASED. Outputs are decoded from state flops; there is no combinational path from inputs.
- Effective request:
  - lc[i]: `rst_lc_req_i[i]`.
  - sys[i]: `rst_sys_req_i[i] | rst_lc_req_i[i] | ~lc_released[i]`. A sys tree is never out of reset while its lc tree is in reset.
- Release permission:
  - lc[0]: always granted.
  - lc[i>0]: granted only when lc[0] is RELEASED.
  - sys[i]: covered by the effective request above.
- Transitions:
  - Any state with effective request 1 → ASSERTED, counter cleared.
  - ASSERTED, request 0, permission 1 → STRETCH, counter = 0.
  - STRETCH, request 0 → counter increments. At counter == RelCycles−1 → RELEASED.
  - STRETCH, request re-asserted → ASSERTED (the stretch aborts and restarts from 0 on the next release).
  - STRETCH, permission lost (e.g. lc[0] re-asserted) → ASSERTED.
  - RELEASED, request 0 → stays RELEASED.
- Sticky cause flags, per domain i:
  - On a cycle where lc[i] or sys[i] enters ASSERTED from a non-ASSERTED state: set `cause_hw_o[i]` if `reset_cause_i`==HwReq; set `cause_lp_o[i]` if it is LowPwrEntry.
  - Other cause values set nothing.
  - `cause_clr_i` clears all flags. If a clear and a set occur in the same cycle, the set wins.
- `seq_busy_o` = OR of all trees in STRETCH (registered-state decode).

## Timing
- Reset values: all tree FSMs ASSERTED; `rst_lc_src_n_o` = 0 and `rst_sys_src_n_o` = 0; counters 0; `cause_*_o` = 0; `seq_busy_o` = 0.
- The async `rst_i` forces the reset state immediately, including mid-stretch. Its deassertion releases nothing until requests are sampled low.
- Assertion latency: request sampled 1 at the edge ending cycle t → `_n` = 0 in cycle t+1.
- Release latency: request sampled 0 with permission at the end of cycle t → STRETCH in cycles t+1..t+RelCycles → `_n` = 1 from cycle t+RelCycles+1.
- Chaining: each dependent tree samples its predecessor's RELEASED state, so every dependency stage adds RelCycles+1 cycles.
- All requests dropping together at the end of cycle t, with R = RelCycles:
  - lc[0] releases at t+R+1.
  - sys[0] and lc[1] release at t+2R+2.
  - sys[1] releases at t+3R+3.
- Low-power path: lc[1] and sys[1] requested while domain 0 stays released. Domain 0 outputs must never glitch.

## Test plan
- Power-on with R=4. Hold all requests 1 for 10 cycles, then drop all at the end of cycle 0 → `rst_lc_src_n_o[0]` rises at cycle 5; `rst_sys_src_n_o[0]` and `rst_lc_src_n_o[1]` at 10; `rst_sys_src_n_o[1]` at 15. `seq_busy_o` is 1 throughout cycles 1–14 except gaps where no tree is in STRETCH.
- From fully released, pulse `rst_lc_req_i[1]` and `rst_sys_req_i[1]` for 3 cycles with `reset_cause_i`=1 → domain-1 outputs go 0 the cycle after the rise; `cause_lp_o` = 2'b10; domain-0 outputs stay 1 every cycle.
- HwReq reset: all requests 1 with `reset_cause_i`=2 from fully released → all outputs 0 in the next cycle; `cause_hw_o` = 2'b11. Assert `cause_clr_i` one cycle → flags return to 0.
- Stretch abort: drop `rst_lc_req_i[0]`, then re-raise it in the 3rd STRETCH cycle → output stays 0. After a second drop, release occurs a full R+1 = 5 cycles after that drop.
- Assert `rst_i` while sys[1] is mid-stretch → all outputs 0 and counters 0 immediately. After `rst_i` falls with requests still 1, the outputs remain 0.
- Set/clear collision: `cause_clr_i`=1 in the same cycle a HwReq assertion occurs → the flag reads 1 the next cycle.
